// File: rtl/mem_port_arbiter_if.sv
// Request/response channel between a memory master and a memory slave.
// Latency: none (wires only). Backpressure: valid/ready on both the request and response phases.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  avalid;
    logic                  aready;
    logic [ADDR_W-1:0]     addr;
    logic                  wen;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wmask;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_W-1:0]     rdata;

    modport master (
        output avalid, addr, wen, wdata, wmask, rready,
        input  aready, rvalid, rdata
    );

    modport slave (
        input  avalid, addr, wen, wdata, wmask, rready,
        output aready, rvalid, rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IFU (m0) and LSU (m1); define ARB_ROUND_ROBIN_EN for round-robin, else fixed m1 > m0.
// Latency: accept cycle 0, s_avalid cycle 1, response passed through combinationally in the cycle s_rvalid rises.
// Backpressure: one transaction outstanding; next grant no earlier than the cycle after the response fires.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    mem_port_arbiter_if.slave    m0,
    mem_port_arbiter_if.slave    m1,
    mem_port_arbiter_if.master   s
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_grant;
    logic                  r_last;
    logic [ADDR_W-1:0]     r_addr;
    logic                  r_wen;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W/8-1:0]   r_wmask;

    logic                  w_any;
    logic                  w_pick;
    logic                  w_afire;
    logic                  w_rready;

    assign w_any = m0.avalid | m1.avalid;

`ifdef ARB_ROUND_ROBIN_EN
    // Contention goes to whoever did not win last; a lone requester always wins.
    assign w_pick = (m0.avalid & m1.avalid) ? ~r_last : m1.avalid;
`else
    logic w_unused_last;
    assign w_unused_last = r_last;
    assign w_pick        = m1.avalid;
`endif

    assign w_rready = r_grant ? m1.rready : m0.rready;

    assign s.addr  = r_addr;
    assign s.wen   = r_wen;
    assign s.wdata = r_wdata;
    assign s.wmask = r_wmask;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_afire     = 1'b0;
        m0.aready   = 1'b0;
        m1.aready   = 1'b0;
        m0.rvalid   = 1'b0;
        m1.rvalid   = 1'b0;
        m0.rdata    = '0;
        m1.rdata    = '0;
        s.avalid    = 1'b0;
        s.rready    = 1'b0;
        // Outputs are held quiet while reset is asserted, whatever state is still registered.
        if (!reset) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        w_afire     = 1'b1;
                        m0.aready   = ~w_pick;
                        m1.aready   = w_pick;
                        w_state_nxt = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    s.avalid = 1'b1;
                    if (s.aready) begin
                        w_state_nxt = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    s.rready = w_rready;
                    if (r_grant) begin
                        m1.rvalid = s.rvalid;
                        m1.rdata  = s.rdata;
                    end else begin
                        m0.rvalid = s.rvalid;
                        m0.rdata  = s.rdata;
                    end
                    if (s.rvalid && w_rready) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_grant <= 1'b0;
            r_last  <= 1'b1;
            r_addr  <= '0;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_wmask <= '0;
        end else if (w_afire) begin
            r_grant <= w_pick;
            r_last  <= w_pick;
            r_addr  <= w_pick ? m1.addr  : m0.addr;
            r_wen   <= w_pick ? m1.wen   : m0.wen;
            r_wdata <= w_pick ? m1.wdata : m0.wdata;
            r_wmask <= w_pick ? m1.wmask : m0.wmask;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vectors, corner sequences and random traffic against a transaction model.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
`ifdef ARB_ROUND_ROBIN_EN
    localparam int BOTH_FIRST = 0;
`else
    localparam int BOTH_FIRST = 1;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_if ();
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_if ();
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) s_if ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock (clock),
        .reset (reset),
        .m0    (m0_if),
        .m1    (m1_if),
        .s     (s_if)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int winner(input bit r0, input bit r1, input bit last);
        if (r0 && r1) begin
`ifdef ARB_ROUND_ROBIN_EN
            return last ? 0 : 1;
`else
            return 1;
`endif
        end
        if (r1) return 1;
        if (r0) return 0;
        return -1;
    endfunction

    function automatic logic [31:0] hash(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Transaction-level model: the port is either free or owned by one master whose
    // request is first offered to the slave and then answered.
    bit          mf_free = 1'b1;
    bit          mf_issued = 1'b0;
    int          m_owner = 0;
    bit          m_last = 1'b1;
    logic [31:0] cap_addr, cap_wdata;
    logic        cap_wen;
    logic [3:0]  cap_wmask;
    bit          f_afire0, f_afire1, f_sacc, f_sfire, f_rfire0, f_rfire1;
    logic [31:0] f_rdat0, f_rdat1, f_saddr;

    always @(negedge clock) begin : monitor
        int w;
        bit resp;
        f_afire0 = 0; f_afire1 = 0; f_sacc = 0; f_sfire = 0; f_rfire0 = 0; f_rfire1 = 0;
        if (reset) begin
            chk("rst_m0_aready", m0_if.aready, 0);
            chk("rst_m1_aready", m1_if.aready, 0);
            chk("rst_m0_rvalid", m0_if.rvalid, 0);
            chk("rst_m1_rvalid", m1_if.rvalid, 0);
            chk("rst_s_avalid",  s_if.avalid, 0);
            chk("rst_s_rready",  s_if.rready, 0);
            mf_free = 1; mf_issued = 0; m_last = 1;
        end else begin
            chk("mon_s_avalid", s_if.avalid, !mf_free && !mf_issued);
            if (s_if.avalid && !mf_free && !mf_issued) begin
                chk("mon_s_addr",  s_if.addr,  cap_addr);
                chk("mon_s_wen",   s_if.wen,   cap_wen);
                chk("mon_s_wdata", s_if.wdata, cap_wdata);
                chk("mon_s_wmask", s_if.wmask, cap_wmask);
            end
            resp = !mf_free && mf_issued;
            chk("mon_m0_rvalid", m0_if.rvalid, resp && m_owner == 0 && s_if.rvalid);
            chk("mon_m1_rvalid", m1_if.rvalid, resp && m_owner == 1 && s_if.rvalid);
            chk("mon_s_rready", s_if.rready, resp && (m_owner == 1 ? m1_if.rready : m0_if.rready));
            if (resp && m_owner == 0) begin
                if (m0_if.rvalid) chk("mon_m0_rdata", m0_if.rdata, s_if.rdata);
                chk("mon_m1_rdata_zero", m1_if.rdata, 0);
            end
            if (resp && m_owner == 1) begin
                if (m1_if.rvalid) chk("mon_m1_rdata", m1_if.rdata, s_if.rdata);
                chk("mon_m0_rdata_zero", m0_if.rdata, 0);
            end
            w = mf_free ? winner(m0_if.avalid, m1_if.avalid, m_last) : -1;
            chk("mon_m0_aready", m0_if.aready, w == 0);
            chk("mon_m1_aready", m1_if.aready, w == 1);
            f_rfire0 = m0_if.rvalid && m0_if.rready; f_rdat0 = m0_if.rdata;
            f_rfire1 = m1_if.rvalid && m1_if.rready; f_rdat1 = m1_if.rdata;
            if (w >= 0) begin
                m_owner = w; m_last = (w == 1); mf_free = 0; mf_issued = 0;
                cap_addr  = (w == 1) ? m1_if.addr  : m0_if.addr;
                cap_wen   = (w == 1) ? m1_if.wen   : m0_if.wen;
                cap_wdata = (w == 1) ? m1_if.wdata : m0_if.wdata;
                cap_wmask = (w == 1) ? m1_if.wmask : m0_if.wmask;
                if (w == 0) f_afire0 = 1; else f_afire1 = 1;
            end else if (!mf_free) begin
                if (!mf_issued && s_if.avalid && s_if.aready) begin
                    mf_issued = 1; f_sacc = 1; f_saddr = s_if.addr;
                end else if (mf_issued && s_if.rvalid && s_if.rready) begin
                    mf_free = 1; f_sfire = 1;
                end
            end
        end
    end

    typedef struct {
        bit          rst;
        bit          v0;
        bit          v1;
        logic [31:0] a0;
        logic [31:0] a1;
        bit          w1;
        logic [31:0] wd1;
        logic [3:0]  wm1;
        int          dly;
        logic [31:0] rd;
        int          first;
    } vec_t;

    function automatic vec_t mk(bit rst, bit v0, bit v1, logic [31:0] a0, logic [31:0] a1, bit w1,
                                logic [31:0] wd1, logic [3:0] wm1, int dly, logic [31:0] rd, int first);
        vec_t v;
        v.rst = rst; v.v0 = v0; v.v1 = v1; v.a0 = a0; v.a1 = a1; v.w1 = w1;
        v.wd1 = wd1; v.wm1 = wm1; v.dly = dly; v.rd = rd; v.first = first;
        return v;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic samp();
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        m0_if.avalid = 0; m0_if.addr = 0; m0_if.wen = 0; m0_if.wdata = 0; m0_if.wmask = 0; m0_if.rready = 1;
        m1_if.avalid = 0; m1_if.addr = 0; m1_if.wen = 0; m1_if.wdata = 0; m1_if.wmask = 0; m1_if.rready = 1;
        s_if.aready = 0; s_if.rvalid = 0; s_if.rdata = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        idle_inputs();
        step();
        samp();
        chk("rst_s_addr",  s_if.addr,  0);
        chk("rst_s_wen",   s_if.wen,   0);
        chk("rst_s_wdata", s_if.wdata, 0);
        chk("rst_s_wmask", s_if.wmask, 0);
        step();
        reset = 0;
    endtask

    task automatic run_vec(input vec_t v);
        int w;
        bit both;
        logic [31:0] inv;
        w = v.first;
        both = v.v0 && v.v1;
        inv = ~v.rd;
        if (v.rst) do_reset();
        m0_if.avalid = v.v0; m0_if.addr = v.a0; m0_if.wen = 0; m0_if.wdata = 0; m0_if.wmask = 4'hF;
        m1_if.avalid = v.v1; m1_if.addr = v.a1; m1_if.wen = v.w1; m1_if.wdata = v.wd1; m1_if.wmask = v.wm1;
        s_if.aready = 1;
        samp();
        chk("vec_aready0", m0_if.aready, w == 0);
        chk("vec_aready1", m1_if.aready, w == 1);
        step();
        if (w == 1) m1_if.avalid = 0; else m0_if.avalid = 0;
        samp();
        chk("vec_s_avalid", s_if.avalid, 1);
        chk("vec_s_addr", s_if.addr, (w == 1) ? v.a1 : v.a0);
        chk("vec_s_wen", s_if.wen, (w == 1) ? v.w1 : 1'b0);
        if (w == 1) begin
            chk("vec_s_wdata", s_if.wdata, v.wd1);
            chk("vec_s_wmask", s_if.wmask, v.wm1);
        end
        chk("vec_issue_no_aready", m0_if.aready | m1_if.aready, 0);
        step();
        s_if.aready = 0;
        for (int i = 0; i < v.dly; i++) begin
            samp();
            chk("vec_early_rvalid", m0_if.rvalid | m1_if.rvalid, 0);
            step();
        end
        s_if.rvalid = 1; s_if.rdata = v.rd;
        samp();
        chk("vec_win_rvalid", (w == 1) ? m1_if.rvalid : m0_if.rvalid, 1);
        chk("vec_win_rdata", (w == 1) ? m1_if.rdata : m0_if.rdata, v.rd);
        chk("vec_lose_rvalid", (w == 1) ? m0_if.rvalid : m1_if.rvalid, 0);
        chk("vec_rfire_no_aready", m0_if.aready | m1_if.aready, 0);
        step();
        s_if.rvalid = 0;
        if (both) begin
            samp();
            chk("vec_loser_aready", (w == 1) ? m0_if.aready : m1_if.aready, 1);
            step();
            m0_if.avalid = 0; m1_if.avalid = 0; s_if.aready = 1;
            samp();
            chk("vec_loser_s_addr", s_if.addr, (w == 1) ? v.a0 : v.a1);
            step();
            s_if.aready = 0; s_if.rvalid = 1; s_if.rdata = inv;
            samp();
            chk("vec_loser_rvalid", (w == 1) ? m0_if.rvalid : m1_if.rvalid, 1);
            chk("vec_loser_rdata", (w == 1) ? m0_if.rdata : m1_if.rdata, inv);
            step();
            s_if.rvalid = 0;
        end
    endtask

    vec_t        vt[6];
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] rnd;
    logic [31:0] s_rd;
    bit          s_pend;
    int          s_cnt;
    int          ndone;

    initial begin
        idle_inputs();
        vt[0] = mk(1, 1, 1, 32'h8000_0100, 32'h8000_2000, 0, 32'h0, 4'hF, 1, 32'h1111_0000, BOTH_FIRST);
        vt[1] = mk(0, 1, 1, 32'h8000_0104, 32'h8000_2004, 0, 32'h0, 4'hF, 0, 32'h2222_0000, BOTH_FIRST);
        vt[2] = mk(0, 1, 1, 32'h8000_0108, 32'h8000_2008, 1, 32'h0BAD_F00D, 4'h3, 2, 32'h3333_0000, BOTH_FIRST);
        vt[3] = mk(1, 0, 1, 32'h0, 32'h8000_1000, 1, 32'hDEAD_BEEF, 4'hF, 1, 32'h0, 1);
        vt[4] = mk(0, 1, 0, 32'h8000_0200, 32'h0, 0, 32'h0, 4'hF, 3, 32'h4444_5555, 0);
        vt[5] = mk(0, 0, 1, 32'h0, 32'h8000_2100, 0, 32'h0, 4'h3, 0, 32'h6666_7777, 1);

        // Single m0 read, slave answers three cycles after accepting.
        do_reset();
        m0_if.avalid = 1; m0_if.addr = 32'h8000_0000; m0_if.wen = 0; m0_if.wmask = 4'hF;
        samp();
        chk("t1_m0_aready", m0_if.aready, 1);
        chk("t1_m1_aready", m1_if.aready, 0);
        step();
        m0_if.avalid = 0; s_if.aready = 1;
        samp();
        chk("t1_s_avalid", s_if.avalid, 1);
        chk("t1_s_addr", s_if.addr, 32'h8000_0000);
        chk("t1_s_wen", s_if.wen, 0);
        step();
        s_if.aready = 0;
        for (int i = 0; i < 2; i++) begin
            samp();
            chk("t1_wait_rvalid", m0_if.rvalid, 0);
            step();
        end
        s_if.rvalid = 1; s_if.rdata = 32'h0000_0413;
        samp();
        chk("t1_m0_rvalid", m0_if.rvalid, 1);
        chk("t1_m0_rdata", m0_if.rdata, 32'h0000_0413);
        chk("t1_m1_rvalid", m1_if.rvalid, 0);
        step();
        s_if.rvalid = 0;
        samp();
        chk("t1_after_rvalid", m0_if.rvalid, 0);
        step();

        for (int i = 0; i < 6; i++) run_vec(vt[i]);

        // Response stalled by m0 while m1 waits.
        m0_if.avalid = 1; m0_if.addr = 32'h8000_0300; m0_if.rready = 0;
        samp();
        chk("t5_m0_aready", m0_if.aready, 1);
        step();
        m0_if.avalid = 0; s_if.aready = 1;
        samp();
        step();
        s_if.aready = 0; s_if.rvalid = 1; s_if.rdata = 32'hCAFE_F00D;
        m1_if.avalid = 1; m1_if.addr = 32'h8000_3000; m1_if.wen = 0;
        for (int i = 0; i < 4; i++) begin
            samp();
            chk("t5_s_rready", s_if.rready, 0);
            chk("t5_m0_rvalid", m0_if.rvalid, 1);
            chk("t5_m0_rdata", m0_if.rdata, 32'hCAFE_F00D);
            chk("t5_m1_aready", m1_if.aready, 0);
            step();
        end
        m0_if.rready = 1;
        samp();
        chk("t5_s_rready_rel", s_if.rready, 1);
        chk("t5_m1_aready_rfire", m1_if.aready, 0);
        step();
        s_if.rvalid = 0;
        samp();
        chk("t5_m1_granted", m1_if.aready, 1);
        step();
        m1_if.avalid = 0; s_if.aready = 1;
        samp();
        chk("t5_m1_s_addr", s_if.addr, 32'h8000_3000);
        step();
        s_if.aready = 0; s_if.rvalid = 1; s_if.rdata = 32'h0000_0005;
        samp();
        chk("t5_m1_rvalid", m1_if.rvalid, 1);
        step();
        s_if.rvalid = 0;

        // Reset while waiting for a response.
        m0_if.avalid = 1; m0_if.addr = 32'h8000_0400;
        samp();
        step();
        m0_if.avalid = 0; s_if.aready = 1;
        samp();
        step();
        s_if.aready = 0;
        samp();
        chk("t6_wait_rvalid", m0_if.rvalid, 0);
        step();
        reset = 1; s_if.rvalid = 1; s_if.rdata = 32'h0000_0BAD;
        samp();
        chk("t6_rst_m0_rvalid", m0_if.rvalid, 0);
        step();
        reset = 0; s_if.rvalid = 0;
        samp();
        chk("t6_idle_s_avalid", s_if.avalid, 0);
        chk("t6_idle_m0_rvalid", m0_if.rvalid, 0);
        chk("t6_idle_s_rready", s_if.rready, 0);
        step();
        m0_if.avalid = 1; m0_if.addr = 32'h8000_0500;
        samp();
        chk("t6_fresh_aready", m0_if.aready, 1);
        step();
        m0_if.avalid = 0; s_if.aready = 1;
        samp();
        chk("t6_fresh_s_addr", s_if.addr, 32'h8000_0500);
        step();
        s_if.aready = 0; s_if.rvalid = 1; s_if.rdata = 32'h0000_0777;
        samp();
        chk("t6_fresh_rvalid", m0_if.rvalid, 1);
        chk("t6_fresh_rdata", m0_if.rdata, 32'h0000_0777);
        step();
        s_if.rvalid = 0;

        // Random traffic: masters expect hash(addr) back, slave answers with hash of what it was sent.
        do_reset();
        s_pend = 0; s_cnt = 0; s_rd = 0; ndone = 0;
        for (int c = 0; c < 3000; c++) begin
            if (f_afire0) begin q0.push_back(hash(m0_if.addr)); m0_if.avalid = 0; end
            if (f_afire1) begin q1.push_back(hash(m1_if.addr)); m1_if.avalid = 0; end
            if (f_rfire0) begin
                chk("rnd_m0_outstanding", q0.size() != 0, 1);
                if (q0.size() != 0) begin chk("rnd_m0_rdata", f_rdat0, q0.pop_front()); ndone++; end
            end
            if (f_rfire1) begin
                chk("rnd_m1_outstanding", q1.size() != 0, 1);
                if (q1.size() != 0) begin chk("rnd_m1_rdata", f_rdat1, q1.pop_front()); ndone++; end
            end
            rnd = $urandom;
            if (!m0_if.avalid && rnd[1:0] == 2'd0) begin
                m0_if.avalid = 1; m0_if.addr = $urandom; m0_if.wen = 0;
                m0_if.wdata = $urandom; m0_if.wmask = rnd[7:4];
            end
            if (!m1_if.avalid && rnd[3:2] == 2'd0) begin
                m1_if.avalid = 1; m1_if.addr = $urandom; m1_if.wen = rnd[8];
                m1_if.wdata = $urandom; m1_if.wmask = rnd[12:9];
            end
            m0_if.rready = rnd[14:13] != 2'd0;
            m1_if.rready = rnd[16:15] != 2'd0;
            if (f_sacc) begin s_pend = 1; s_cnt = int'(rnd[18:17]); s_rd = hash(f_saddr); end
            if (f_sfire) begin s_if.rvalid = 0; s_pend = 0; end
            if (s_pend && !s_if.rvalid) begin
                if (s_cnt == 0) begin s_if.rvalid = 1; s_if.rdata = s_rd; end
                else s_cnt--;
            end
            if (!s_if.rvalid) s_if.rdata = $urandom;
            s_if.aready = rnd[20:19] != 2'd0;
            samp();
            step();
        end
        chk("rnd_enough_done", ndone > 50, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
